// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with a registered result, iterative shift-add multiply and
// optional restoring divide (built only when ALU_ITER_DIV_EN is defined).
module alu_iter #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       OP,
   input  logic [WIDTH-1:0] Port_A,
   input  logic [WIDTH-1:0] Port_B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam logic [3:0] OP_SLL  = 4'd0,  OP_SRL  = 4'd1,  OP_SRA   = 4'd2,  OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4,  OP_AND  = 4'd5,  OP_OR    = 4'd6,  OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU  = 4'd10, OP_MULT = 4'd11;
   localparam logic [3:0] OP_MULTU = 4'd12, OP_DIV = 4'd13, OP_DIVU  = 4'd14;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               accept, is_mul, is_sign;
   logic [SHW-1:0]     amt;
   logic [WIDTH-1:0]   a_mag, b_mag, add_res, sub_res;
   logic [WIDTH-1:0]   sc_lo, sc_hi;
   logic               sc_ovf, sc_dbz;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q, opb_q;
   logic               neg_lo_q;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_raw, prod_fin;
   logic [WIDTH-1:0]   res_lo_q, res_hi_q;
   logic               zero_q, neg_q, ovf_q, dbz_q;
`ifdef ALU_ITER_DIV_EN
   logic               is_div, b_zero, div_q, neg_hi_q, div_ovf_q;
   logic [WIDTH:0]     div_shift, div_trial;

   assign is_div    = (OP == OP_DIV) || (OP == OP_DIVU);
   assign b_zero    = (Port_B == '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opb_q};
`endif

   assign accept  = in_valid && (state_q == S_IDLE);
   assign is_mul  = (OP == OP_MULT) || (OP == OP_MULTU);
   assign is_sign = (OP == OP_MULT) || (OP == OP_DIV);
   assign amt     = Port_B[SHW-1:0];
   assign add_res = Port_A + Port_B;
   assign sub_res = Port_A - Port_B;
   // Signed multiply/divide run on magnitudes; the sign is re-applied at the end.
   assign a_mag   = (is_sign && Port_A[WIDTH-1]) ? (~Port_A + 1'b1) : Port_A;
   assign b_mag   = (is_sign && Port_B[WIDTH-1]) ? (~Port_B + 1'b1) : Port_B;

   // One shift-add step; prod_raw is the product after this step, used on the last one.
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
   assign prod_raw = {mul_sum, lo_q[WIDTH-1:1]};
   assign prod_fin = neg_lo_q ? (~prod_raw + 1'b1) : prod_raw;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      sc_lo  = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_dbz = 1'b0;
      case (OP)
         OP_SLL:  sc_lo = Port_A << amt;
         OP_SRL:  sc_lo = Port_A >> amt;
         OP_SRA:  sc_lo = $signed(Port_A) >>> amt;
         OP_ADD: begin
            sc_lo  = add_res;
            sc_ovf = (Port_A[WIDTH-1] == Port_B[WIDTH-1]) && (add_res[WIDTH-1] != Port_A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_lo  = sub_res;
            sc_ovf = (Port_A[WIDTH-1] != Port_B[WIDTH-1]) && (sub_res[WIDTH-1] != Port_A[WIDTH-1]);
         end
         OP_AND:  sc_lo = Port_A & Port_B;
         OP_OR:   sc_lo = Port_A | Port_B;
         OP_XOR:  sc_lo = Port_A ^ Port_B;
         OP_NOR:  sc_lo = ~(Port_A | Port_B);
         OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(Port_A) < $signed(Port_B))};
         OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (Port_A < Port_B)};
`ifdef ALU_ITER_DIV_EN
         // Only reaches the result registers on divide-by-zero; real divides go to CALC.
         OP_DIV, OP_DIVU: begin
            sc_lo  = '1;
            sc_hi  = Port_A;
            sc_dbz = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // State register
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_mul) state_d = S_CALC;
`ifdef ALU_ITER_DIV_EN
               else if (is_div && !b_zero) state_d = S_CALC;
`endif
               else state_d = S_DONE;
            end
         end
         S_CALC: begin
            if (&cnt_q) begin
`ifdef ALU_ITER_DIV_EN
               if (div_q) state_d = S_FIX;
               else
`endif
               state_d = S_DONE;
            end
         end
`ifdef ALU_ITER_DIV_EN
         S_FIX:  state_d = S_DONE;
`endif
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opb_q     <= '0;
         neg_lo_q  <= 1'b0;
         res_lo_q  <= '0;
         res_hi_q  <= '0;
         zero_q    <= 1'b0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
`ifdef ALU_ITER_DIV_EN
         div_q     <= 1'b0;
         neg_hi_q  <= 1'b0;
         div_ovf_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               cnt_q    <= '0;
               neg_lo_q <= is_sign && (Port_A[WIDTH-1] ^ Port_B[WIDTH-1]);
`ifdef ALU_ITER_DIV_EN
               div_q     <= is_div;
               neg_hi_q  <= is_sign && Port_A[WIDTH-1];
               div_ovf_q <= is_sign && (Port_A == {1'b1, {(WIDTH-1){1'b0}}}) && (&Port_B);
`endif
               if (is_mul) begin
                  hi_q  <= '0;
                  lo_q  <= b_mag;
                  opb_q <= a_mag;
               end
`ifdef ALU_ITER_DIV_EN
               else if (is_div && !b_zero) begin
                  hi_q  <= '0;
                  lo_q  <= a_mag;
                  opb_q <= b_mag;
               end
`endif
               else begin
                  res_lo_q <= sc_lo;
                  res_hi_q <= sc_hi;
                  zero_q   <= (sc_lo == '0);
                  neg_q    <= sc_lo[WIDTH-1];
                  ovf_q    <= sc_ovf;
                  dbz_q    <= sc_dbz;
               end
            end
            S_CALC: begin
               cnt_q <= cnt_q + 1'b1;
`ifdef ALU_ITER_DIV_EN
               if (div_q) begin
                  if (!div_trial[WIDTH]) begin
                     hi_q <= div_trial[WIDTH-1:0];
                     lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     hi_q <= div_shift[WIDTH-1:0];
                     lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                  end
               end else
`endif
               begin
                  hi_q <= mul_sum[WIDTH:1];
                  lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                  if (&cnt_q) begin
                     res_lo_q <= prod_fin[WIDTH-1:0];
                     res_hi_q <= prod_fin[2*WIDTH-1:WIDTH];
                     zero_q   <= (prod_fin[WIDTH-1:0] == '0);
                     neg_q    <= prod_fin[WIDTH-1];
                     ovf_q    <= 1'b0;
                     dbz_q    <= 1'b0;
                  end
               end
            end
`ifdef ALU_ITER_DIV_EN
            S_FIX: begin
               res_lo_q <= neg_lo_q ? (~lo_q + 1'b1) : lo_q;
               res_hi_q <= neg_hi_q ? (~hi_q + 1'b1) : hi_q;
               zero_q   <= (lo_q == '0);
               neg_q    <= neg_lo_q ? (~lo_q + 1'b1) >> (WIDTH-1) != '0 : lo_q[WIDTH-1];
               ovf_q    <= div_ovf_q;
               dbz_q    <= 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      in_ready    = (state_q == S_IDLE);
      out_valid   = (state_q == S_DONE);
      result_lo   = res_lo_q;
      result_hi   = res_hi_q;
      zero        = zero_q;
      negative    = neg_q;
      overflow    = ovf_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: scoreboard of model results, popped when out_valid rises.
module tb_alu_iter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  OP;
   logic [31:0] Port_A, Port_B, result_lo, result_hi;
   logic        zero, negative, overflow, div_by_zero;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        z, n, o, d;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   alu_iter #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .OP(OP),
      .Port_A(Port_A), .Port_B(Port_B), .out_valid(out_valid), .out_ready(out_ready),
      .result_lo(result_lo), .result_hi(result_hi), .zero(zero), .negative(negative),
      .overflow(overflow), .div_by_zero(div_by_zero)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      sa, sb_, q, r;
      logic [4:0]  sh;
      e.lo = '0; e.hi = '0; e.o = 1'b0; e.d = 1'b0; e.lat = 1;
      sh = b[4:0];
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      case (op)
         4'd0:  e.lo = a << sh;
         4'd1:  e.lo = a >> sh;
         4'd2:  e.lo = $signed(a) >>> sh;
         4'd3: begin e.lo = a + b; e.o = (a[31] == b[31]) && (e.lo[31] != a[31]); end
         4'd4: begin e.lo = a - b; e.o = (a[31] != b[31]) && (e.lo[31] != a[31]); end
         4'd5:  e.lo = a & b;
         4'd6:  e.lo = a | b;
         4'd7:  e.lo = a ^ b;
         4'd8:  e.lo = ~(a | b);
         4'd9:  e.lo = {31'b0, (sa < sb_)};
         4'd10: e.lo = {31'b0, (a < b)};
         4'd11: begin p = 64'(sa * sb_); e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
         4'd12: begin p = {32'b0, a} * {32'b0, b}; e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
`ifdef ALU_ITER_DIV_EN
         4'd13, 4'd14: begin
            if (b == 32'd0) begin
               e.lo = '1; e.hi = a; e.d = 1'b1;
            end else begin
               if (op == 4'd14) begin sa = longint'({32'b0, a}); sb_ = longint'({32'b0, b}); end
               q = sa / sb_;
               r = sa % sb_;
               p = 64'(q); e.lo = p[31:0];
               p = 64'(r); e.hi = p[31:0];
               e.o = (op == 4'd13) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
               e.lat = 34;
            end
         end
`endif
         default: ;
      endcase
      e.z = (e.lo == 32'd0);
      e.n = e.lo[31];
      return e;
   endfunction

   // Issue one op, wait for out_valid (bounded), compare against the scoreboard, then
   // hold out_ready low for 'hold' result cycles before draining.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      exp_t e;
      int   lat;
      logic saw_ready;
      sb.push_back(model(op, a, b));
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      OP = op; Port_A = a; Port_B = b;
      check("in_ready_idle", in_ready, 1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      OP = 4'($urandom); Port_A = $urandom; Port_B = $urandom;
      lat = 1;
      saw_ready = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge CLK); #1;
         lat++;
      end
      check("sb_not_empty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("latency", lat, e.lat);
         check("result_lo", result_lo, e.lo);
         check("result_hi", result_hi, e.hi);
         check("flags_znod", {zero, negative, overflow, div_by_zero}, {e.z, e.n, e.o, e.d});
         check("busy_ready_low", saw_ready, 0);
         for (int i = 0; i < hold; i++) begin
            check("hold_valid", {out_valid, in_ready}, 2'b10);
            check("hold_lo", result_lo, e.lo);
            @(posedge CLK); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      check("drain_idle", {out_valid, in_ready}, 2'b01);
      out_ready = 1'b0;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      OP = '0; Port_A = '0; Port_B = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_handshake", {in_ready, out_valid}, 2'b10);
      check("rst_lo", result_lo, 0);
      check("rst_hi", result_hi, 0);
      check("rst_flags", {zero, negative, overflow, div_by_zero}, 0);

      // Reset wins over a request in the same cycle.
      in_valid = 1'b1; OP = 4'd3; Port_A = 32'd5; Port_B = 32'd6;
      @(posedge CLK); #1;
      check("rst_prio", {in_ready, out_valid}, 2'b10);
      in_valid = 1'b0;
      RST = 1'b0;

      run_op(4'd3, 32'h7FFF_FFFF, 32'd1, 0);
      run_op(4'd4, 32'h8000_0000, 32'd1, 0);
      run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd11, 32'hFFFF_FFFD, 32'd5, 0);
      run_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(4'd11, 32'h8000_0000, 32'h8000_0000, 1);
`ifdef ALU_ITER_DIV_EN
      run_op(4'd13, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(4'd13, 32'd7, 32'hFFFF_FFFE, 0);
      run_op(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(4'd14, 32'd100, 32'd7, 0);
      run_op(4'd14, 32'h0000_1234, 32'd0, 0);
      run_op(4'd13, 32'hFFFF_FFF0, 32'd0, 0);
`else
      run_op(4'd13, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(4'd14, 32'h0000_1234, 32'd0, 0);
`endif
      run_op(4'd2, 32'h8000_0000, 32'h24, 5);
      run_op(4'd0, 32'hA5A5_0001, 32'd0, 0);
      run_op(4'd1, 32'h8000_0000, 32'd31, 0);
      run_op(4'd8, 32'h0F0F_0F0F, 32'hF0F0_0000, 0);
      run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd10, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 2);

      // Abort a MULTU ten cycles in; nothing partial may surface afterwards.
      out_ready = 1'b0;
      in_valid = 1'b1; OP = 4'd12; Port_A = 32'hDEAD_BEEF; Port_B = 32'h0001_2345;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge CLK); #1; end
      check("busy_before_rst", {in_ready, out_valid}, 2'b00);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("abort_handshake", {in_ready, out_valid}, 2'b10);
      check("abort_lo", result_lo, 0);
      check("abort_hi", result_hi, 0);
      check("abort_flags", {zero, negative, overflow, div_by_zero}, 0);
      repeat (40) begin @(posedge CLK); #1; end
      check("abort_no_result", {in_ready, out_valid}, 2'b10);
      run_op(4'd10, 32'd1, 32'hFFFF_FFFF, 0);

      for (int k = 0; k < 20; k++) begin
         run_op(4'($urandom_range(15)), $urandom, (k % 4 == 0) ? 32'($urandom_range(31)) : $urandom,
                $urandom_range(2));
      end

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
